// File: rtl/int_controller.sv
// rtl/int_controller.sv - edge-latched, masked, fixed-priority interrupt controller for the 8-bit CPU
// Dispatches one source at a time: a one-cycle int_req pulse, then holds until software writes EOI.
module int_controller #(
    parameter int         N_SRC     = 4,
    parameter logic [7:0] BASE_ADDR = 8'hF8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [N_SRC-1:0] irq_in,
    input  logic [7:0]       addr,
    input  logic [7:0]       w_data,
    input  logic             w_en,
    output logic [7:0]       r_data,
    output logic             int_req,
    output logic [7:0]       int_en,
    output logic [7:0]       int_vec
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPATCH = 2'd1,
        SERVICE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             gie_q, gie_d;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic [N_SRC-1:0] pend_q, pend_d;
    logic [N_SRC-1:0] irq_prev_q;
    logic [3:0][7:0]  vec_q, vec_d;
    logic [2:0]       active_id_q, active_id_d;
    logic             in_service_q, in_service_d;
    logic             int_req_q, int_req_d;
    logic [7:0]       int_vec_q, int_vec_d;

    logic             hit, wr, eoi;
    logic [2:0]       off;
    logic [N_SRC-1:0] eligible, rise, wclr, dclr;
    logic             sel_found, dispatch;
    logic [2:0]       sel_id;

    assign hit      = (addr[7:3] == BASE_ADDR[7:3]);
    assign off      = addr[2:0];
    assign wr       = w_en && hit;
    assign eoi      = wr && (off == 3'd3);
    assign eligible = pend_q & mask_q;
    assign rise     = irq_in & ~irq_prev_q;
    assign wclr     = (wr && off == 3'd2) ? w_data[N_SRC-1:0] : '0;

    // Descending scan so the lowest-indexed eligible source is the one left selected.
    always_comb begin
        sel_found = 1'b0;
        sel_id    = 3'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                sel_found = 1'b1;
                sel_id    = 3'(i);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        active_id_d  = active_id_q;
        in_service_d = in_service_q;
        int_req_d    = 1'b0;
        int_vec_d    = int_vec_q;
        dispatch     = 1'b0;
        case (state_q)
            IDLE: begin
                if (gie_q && sel_found) begin
                    dispatch    = 1'b1;
                    active_id_d = sel_id;
                    int_vec_d   = vec_q[sel_id[1:0]];
                    int_req_d   = 1'b1;
                    state_d     = DISPATCH;
                end
            end
            DISPATCH: begin
                in_service_d = 1'b1;
                state_d      = SERVICE;
            end
            SERVICE: begin
                if (eoi) begin
                    in_service_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dclr = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (dispatch && sel_id == 3'(i)) dclr[i] = 1'b1;
        end
    end

    // A fresh edge is OR-ed in last so it survives both software clear and dispatch clear.
    always_comb begin
        gie_d  = gie_q;
        mask_d = mask_q;
        vec_d  = vec_q;
        pend_d = (pend_q & ~wclr & ~dclr) | rise;
        if (wr) begin
            case (off)
                3'd0:    gie_d  = w_data[0];
                3'd1:    mask_d = w_data[N_SRC-1:0];
                3'd2:    ;
                3'd3:    ;
                default: vec_d[off[1:0]] = w_data;
            endcase
        end
    end

    always_comb begin
        r_data = 8'h00;
        if (hit) begin
            case (off)
                3'd0:    r_data = {7'b0, gie_q};
                3'd1:    r_data = 8'(mask_q);
                3'd2:    r_data = 8'(pend_q);
                3'd3:    r_data = {in_service_q, 4'b0, active_id_q};
                default: r_data = vec_q[off[1:0]];
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            gie_q        <= 1'b0;
            mask_q       <= '0;
            pend_q       <= '0;
            irq_prev_q   <= '0;
            vec_q        <= '0;
            active_id_q  <= 3'd0;
            in_service_q <= 1'b0;
            int_req_q    <= 1'b0;
            int_vec_q    <= 8'h00;
        end else begin
            state_q      <= state_d;
            gie_q        <= gie_d;
            mask_q       <= mask_d;
            pend_q       <= pend_d;
            irq_prev_q   <= irq_in;
            vec_q        <= vec_d;
            active_id_q  <= active_id_d;
            in_service_q <= in_service_d;
            int_req_q    <= int_req_d;
            int_vec_q    <= int_vec_d;
        end
    end

    assign int_req = int_req_q;
    assign int_vec = int_vec_q;
    assign int_en  = {7'b0, gie_q};

endmodule

// File: tb/tb_int_controller.sv
// tb/tb_int_controller.sv - table-driven and sequence checks for int_controller
module tb_int_controller;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [3:0] irq_in;
    logic [7:0] addr, w_data;
    logic       w_en;
    logic [7:0] r_data;
    logic       int_req;
    logic [7:0] int_en, int_vec;

    int n_pass = 0;
    int n_total = 0;

    int_controller #(.N_SRC(4), .BASE_ADDR(8'hF8)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .irq_in (irq_in),
        .addr   (addr),
        .w_data (w_data),
        .w_en   (w_en),
        .r_data (r_data),
        .int_req(int_req),
        .int_en (int_en),
        .int_vec(int_vec)
    );

    always #5 clock = ~clock;

    // Row: inputs for one cycle, r_data expected before the edge, registered outputs after it.
    typedef struct {
        logic [7:0] a;
        logic [7:0] wd;
        logic       we;
        logic [3:0] irq;
        logic [7:0] rd;
        logic       req;
        logic [7:0] vec;
        logic [7:0] en;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] wd, input logic we, input logic [3:0] irq);
        addr = a; w_data = wd; w_en = we; irq_in = irq;
    endtask

    task automatic step(input logic [7:0] a, input logic [7:0] wd, input logic we, input logic [3:0] irq);
        drive(a, wd, we, irq);
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic rd_check(input string name, input logic [7:0] a, input logic [3:0] irq, input logic [7:0] exp);
        drive(a, 8'h00, 1'b0, irq);
        #1;
        check(name, r_data, exp);
    endtask

    initial begin
        int pulses;
        reset_n = 1'b0;
        drive(8'h00, 8'h00, 1'b0, 4'h0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        check("reset_int_req", {7'b0, int_req}, 8'h00);
        check("reset_int_vec", int_vec, 8'h00);
        check("reset_int_en", int_en, 8'h00);
        rd_check("reset_stat", 8'hFB, 4'h0, 8'h00);

        //            addr   wdata  we    irq    rd     req   vec    en
        vq.push_back('{8'hF8, 8'h01, 1'b1, 4'h0, 8'h00, 1'b0, 8'h00, 8'h01});
        vq.push_back('{8'hF9, 8'h0F, 1'b1, 4'h0, 8'h00, 1'b0, 8'h00, 8'h01});
        vq.push_back('{8'hFE, 8'h30, 1'b1, 4'h0, 8'h00, 1'b0, 8'h00, 8'h01});
        vq.push_back('{8'hF9, 8'h00, 1'b0, 4'h0, 8'h0F, 1'b0, 8'h00, 8'h01});
        vq.push_back('{8'hFA, 8'h00, 1'b0, 4'h4, 8'h00, 1'b0, 8'h00, 8'h01});
        vq.push_back('{8'hFA, 8'h00, 1'b0, 4'h4, 8'h04, 1'b1, 8'h30, 8'h01});
        vq.push_back('{8'hFB, 8'h00, 1'b0, 4'h4, 8'h02, 1'b0, 8'h30, 8'h01});
        vq.push_back('{8'hFB, 8'h00, 1'b0, 4'h4, 8'h82, 1'b0, 8'h30, 8'h01});
        vq.push_back('{8'hFA, 8'h00, 1'b0, 4'h4, 8'h00, 1'b0, 8'h30, 8'h01});
        vq.push_back('{8'hFB, 8'h00, 1'b1, 4'h4, 8'h82, 1'b0, 8'h30, 8'h01});
        vq.push_back('{8'hFB, 8'h00, 1'b0, 4'h0, 8'h02, 1'b0, 8'h30, 8'h01});
        vq.push_back('{8'hFD, 8'h10, 1'b1, 4'h0, 8'h00, 1'b0, 8'h30, 8'h01});
        vq.push_back('{8'hFF, 8'h20, 1'b1, 4'h0, 8'h00, 1'b0, 8'h30, 8'h01});
        vq.push_back('{8'h00, 8'h00, 1'b0, 4'hA, 8'h00, 1'b0, 8'h30, 8'h01});
        vq.push_back('{8'hFA, 8'h00, 1'b0, 4'hA, 8'h0A, 1'b1, 8'h10, 8'h01});
        vq.push_back('{8'hFA, 8'h00, 1'b0, 4'hA, 8'h08, 1'b0, 8'h10, 8'h01});
        vq.push_back('{8'hFB, 8'h00, 1'b0, 4'hA, 8'h81, 1'b0, 8'h10, 8'h01});
        vq.push_back('{8'hFB, 8'h00, 1'b0, 4'hA, 8'h81, 1'b0, 8'h10, 8'h01});
        vq.push_back('{8'hFB, 8'h00, 1'b1, 4'hA, 8'h81, 1'b0, 8'h10, 8'h01});
        vq.push_back('{8'hFA, 8'h00, 1'b0, 4'hA, 8'h08, 1'b1, 8'h20, 8'h01});
        vq.push_back('{8'hFB, 8'h00, 1'b0, 4'hA, 8'h03, 1'b0, 8'h20, 8'h01});
        vq.push_back('{8'hFB, 8'h00, 1'b1, 4'hA, 8'h83, 1'b0, 8'h20, 8'h01});
        vq.push_back('{8'hFA, 8'h00, 1'b0, 4'h0, 8'h00, 1'b0, 8'h20, 8'h01});

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].a, vq[i].wd, vq[i].we, vq[i].irq);
            #1;
            check($sformatf("row%0d_r_data", i), r_data, vq[i].rd);
            @(posedge clock);
            @(negedge clock);
            check($sformatf("row%0d_int_req", i), {7'b0, int_req}, {7'b0, vq[i].req});
            check($sformatf("row%0d_int_vec", i), int_vec, vq[i].vec);
            check($sformatf("row%0d_int_en", i), int_en, vq[i].en);
        end

        // Masked source stays pending, then dispatches once unmasked.
        step(8'hFC, 8'h55, 1'b1, 4'h0);
        step(8'hF9, 8'h0E, 1'b1, 4'h0);
        step(8'h00, 8'h00, 1'b0, 4'h1);
        check("mask_no_req_a", {7'b0, int_req}, 8'h00);
        step(8'h00, 8'h00, 1'b0, 4'h1);
        check("mask_no_req_b", {7'b0, int_req}, 8'h00);
        rd_check("mask_pend", 8'hFA, 4'h1, 8'h01);
        step(8'hF9, 8'h0F, 1'b1, 4'h1);
        check("unmask_edge_req", {7'b0, int_req}, 8'h00);
        step(8'h00, 8'h00, 1'b0, 4'h1);
        check("unmask_req", {7'b0, int_req}, 8'h01);
        check("unmask_vec", int_vec, 8'h55);
        step(8'h00, 8'h00, 1'b0, 4'h1);
        step(8'hFB, 8'h00, 1'b1, 4'h0);
        step(8'h00, 8'h00, 1'b0, 4'h0);

        // Level-held line: one dispatch only, even across an EOI.
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) step(8'hFB, 8'h00, 1'b1, 4'h2);
            else step(8'h00, 8'h00, 1'b0, 4'h2);
            if (int_req) pulses++;
        end
        check("level_pulses", 8'(pulses), 8'h01);
        check("level_vec", int_vec, 8'h10);

        // Edge set wins over a same-cycle write-1-clear; a lone clear works.
        step(8'hF8, 8'h00, 1'b1, 4'h2);
        step(8'h00, 8'h00, 1'b0, 4'h0);
        step(8'hFA, 8'h02, 1'b1, 4'h2);
        rd_check("set_beats_w1c", 8'hFA, 4'h2, 8'h02);
        step(8'hFA, 8'h02, 1'b1, 4'h2);
        rd_check("w1c_clears", 8'hFA, 4'h2, 8'h00);
        check("w1c_no_req", {7'b0, int_req}, 8'h00);

        // gie gating, and gie clear during service does not abort it.
        step(8'h00, 8'h00, 1'b0, 4'h0);
        step(8'h00, 8'h00, 1'b0, 4'h2);
        check("gie_off_en", int_en, 8'h00);
        check("gie_off_req_a", {7'b0, int_req}, 8'h00);
        step(8'h00, 8'h00, 1'b0, 4'h2);
        check("gie_off_req_b", {7'b0, int_req}, 8'h00);
        step(8'hF8, 8'h01, 1'b1, 4'h2);
        check("gie_on_en", int_en, 8'h01);
        check("gie_on_req_first", {7'b0, int_req}, 8'h00);
        step(8'h00, 8'h00, 1'b0, 4'h2);
        check("gie_on_req", {7'b0, int_req}, 8'h01);
        check("gie_on_vec", int_vec, 8'h10);
        step(8'h00, 8'h00, 1'b0, 4'h2);
        step(8'hF8, 8'h00, 1'b1, 4'h2);
        rd_check("gie_clear_keeps_service", 8'hFB, 4'h2, 8'h81);
        check("gie_clear_en", int_en, 8'h00);
        step(8'hFB, 8'h00, 1'b1, 4'h2);
        rd_check("gie_clear_eoi", 8'hFB, 4'h2, 8'h01);

        // Asynchronous reset mid-service.
        step(8'hF8, 8'h01, 1'b1, 4'h0);
        step(8'hFC, 8'h40, 1'b1, 4'h0);
        step(8'h00, 8'h00, 1'b0, 4'h1);
        step(8'h00, 8'h00, 1'b0, 4'h1);
        check("pre_reset_req", {7'b0, int_req}, 8'h01);
        step(8'h00, 8'h00, 1'b0, 4'h1);
        check("pre_reset_vec", int_vec, 8'h40);
        rd_check("pre_reset_stat", 8'hFB, 4'h1, 8'h80);
        #1;
        reset_n = 1'b0;
        #1;
        check("async_reset_req", {7'b0, int_req}, 8'h00);
        check("async_reset_vec", int_vec, 8'h00);
        check("async_reset_en", int_en, 8'h00);
        @(negedge clock);
        reset_n = 1'b1;
        rd_check("post_reset_stat", 8'hFB, 4'h0, 8'h00);
        rd_check("post_reset_mask", 8'hF9, 4'h0, 8'h00);
        rd_check("miss_reads_zero", 8'h10, 4'h0, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
